debug_bus_master: RTL and testbench

DEBUG_BUS_MASTER -- requirements
Module: debug_bus_master

---
 rtl/debug_bus_master.sv | 126 ++++++++++++
 tb/tb_debug_bus_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/debug_bus_master.sv
// debug_bus_master: byte-stream command decoder driving a 32-bit word bus and returning response bytes.
// Ports: clk, reset (async, active-high);
//        rx_data/rx_valid/rx_ready  command bytes in (0x01 read, 0x02 write, then addr LSB-first, then wdata for writes);
//        tx_data/tx_valid/tx_ready  response bytes out (read data LSB-first, 0xAA write ack, 0xEE timeout);
//        mem_valid/mem_addr/mem_wdata/mem_wstrb/mem_ready/mem_rdata  bus request and completion;
//        busy  high whenever a command is in progress.
module debug_bus_master #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;
   state_t      state_q, state_d;
   logic        wr_q, wr_d, err_q, err_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [7:0]  wait_q, wait_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic        rx_ready_q, tx_valid_q, mem_valid_q, busy_q;
   logic        rx_fire, tx_fire, last_tx;
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      wait_d  = wait_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rx_fire = rx_valid && rx_ready_q;
      tx_fire = tx_valid_q && tx_ready;
      // write acks and timeout errors are a single byte; reads return four
      last_tx = err_q || wr_q || cnt_q == 2'd3;
      case (state_q)
         IDLE: if (rx_fire && (rx_data == 8'h01 || rx_data == 8'h02)) begin
            wr_d    = rx_data[1];
            err_d   = 1'b0;
            cnt_d   = 2'd0;
            state_d = ADDR;
         end
         ADDR: if (rx_fire) begin
            addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = wr_q ? WDATA : BUS;
               wait_d  = 8'd0;
            end
         end
         WDATA: if (rx_fire) begin
            wdata_d[{cnt_q, 3'b000} +: 8] = rx_data;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = BUS;
               wait_d  = 8'd0;
            end
         end
         // completion is checked before the timeout so a late ready still wins
         BUS: if (mem_ready) begin
            rdata_d = wr_q ? rdata_q : mem_rdata;
            cnt_d   = 2'd0;
            state_d = RESP;
         end else if (wait_q == 8'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            cnt_d   = 2'd0;
            state_d = RESP;
         end else begin
            wait_d = wait_q + 8'd1;
         end
         RESP: if (tx_fire) begin
            cnt_d   = last_tx ? 2'd0 : cnt_q + 2'd1;
            state_d = last_tx ? IDLE : RESP;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= 2'd0;
         wait_q      <= 8'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         rdata_q     <= 32'd0;
         rx_ready_q  <= 1'b0;
         tx_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         wait_q      <= wait_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rx_ready_q  <= state_d inside {IDLE, ADDR, WDATA};
         tx_valid_q  <= state_d == RESP;
         mem_valid_q <= state_d == BUS;
         busy_q      <= state_d != IDLE;
      end
   end
   assign rx_ready  = rx_ready_q;
   assign tx_valid  = tx_valid_q;
   assign mem_valid = mem_valid_q;
   assign busy      = busy_q;
   assign mem_addr  = addr_q & 32'hFFFF_FFFC;
   assign mem_wstrb = {4{wr_q}};
   assign mem_wdata = wr_q ? wdata_q : 32'd0;
   assign tx_data   = !tx_valid_q ? 8'h00 : err_q ? 8'hEE : wr_q ? 8'hAA : rdata_q[{cnt_q, 3'b000} +: 8];
endmodule

// File: tb/tb_debug_bus_master.sv
// tb_debug_bus_master: directed self-checking bench for debug_bus_master.
// Ports: none; drives every DUT port and reports one summary line.
module tb_debug_bus_master;
   localparam int TO = 8;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic        mem_valid;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        busy;
   int          n_chk = 0;
   int          n_fail = 0;

   debug_bus_master #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_ctl"}, {22'd0, rx_ready, tx_valid, mem_valid, busy, mem_wstrb, tx_data}, 32'd0);
      check({tag, "_addr"}, mem_addr, 32'd0);
      check({tag, "_wdata"}, mem_wdata, 32'd0);
   endtask

   task automatic check_idle();
      check("idle_busy", busy, 1'b0);
      check("idle_tx_valid", tx_valid, 1'b0);
      check("idle_rx_ready", rx_ready, 1'b1);
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      int n;
      n = 0;
      repeat (gap) @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("rx_ready_wait", rx_ready, 1'b1);
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic cmd(input logic [71:0] v, input int nb, input int gap);
      for (int i = nb - 1; i >= 0; i--) send(v[8*i +: 8], gap);
   endtask

   task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                      input int lat, input logic [31:0] rd);
      check("mv_rise", mem_valid, 1'b1);
      for (int i = 0; i < lat; i++) begin
         check("addr_hold", mem_addr, a);
         check("wstrb_hold", {28'd0, mem_wstrb}, {28'd0, ws});
         @(negedge clk);
      end
      check("mv_at_ready", mem_valid, 1'b1);
      check("addr", mem_addr, a);
      check("wdata", mem_wdata, wd);
      check("wstrb", {28'd0, mem_wstrb}, {28'd0, ws});
      mem_ready = 1'b1;
      mem_rdata = rd;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'd0;
      check("mv_drop", mem_valid, 1'b0);
   endtask

   task automatic recv(input logic [7:0] b, input int stall);
      for (int i = 0; i < stall; i++) begin
         check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, b});
         @(negedge clk);
      end
      check("tx_byte", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, b});
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
   endtask

   initial begin
      #2 reset = 1'b1;
      #2 check_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      // write 0x12345678 to 0x00020010, slave waits 3 cycles
      cmd(72'h02_10_00_02_00_78_56_34_12, 9, 0);
      bus(32'h0002_0010, 32'h1234_5678, 4'hF, 3, 32'd0);
      recv(8'hAA, 0);
      check_idle();

      // read from 0x80000000
      cmd(72'h01_00_00_00_80, 5, 0);
      bus(32'h8000_0000, 32'd0, 4'h0, 1, 32'h0000_002A);
      recv(8'h2A, 0);
      recv(8'h00, 0);
      recv(8'h00, 0);
      recv(8'h00, 0);
      check_idle();

      // timeout with mem_ready held low
      begin
         int n;
         cmd(72'h01_00_30_00_00, 5, 0);
         n = 0;
         while (mem_valid && n < 300) begin
            check("to_addr", mem_addr, 32'h0000_3000);
            n++;
            @(negedge clk);
         end
         check("to_len", n, TO);
         recv(8'hEE, 0);
         check_idle();
      end

      // garbage byte, slow rx and stalled tx
      send(8'h5A, 0);
      check("garbage_busy", busy, 1'b0);
      cmd(72'h01_03_01_02_00, 5, 5);
      bus(32'h0002_0100, 32'd0, 4'h0, 2, 32'hDEAD_BEEF);
      recv(8'hEF, 4);
      recv(8'hBE, 4);
      recv(8'hAD, 4);
      recv(8'hDE, 4);
      check_idle();

      // reset after the third address byte
      cmd(72'h01_44_33_22, 4, 0);
      check("mid_busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1 check_zero("mid_reset");
      @(negedge clk);
      reset = 1'b0;
      cmd(72'h01_44_33_22_11, 5, 0);
      bus(32'h1122_3344, 32'd0, 4'h0, 0, 32'hCAFE_F00D);
      recv(8'h0D, 0);
      recv(8'hF0, 0);
      recv(8'hFE, 0);
      recv(8'hCA, 0);
      check_idle();

      // ready on the final timeout cycle wins over the error
      cmd(72'h01_08_00_00_00, 5, 0);
      bus(32'h0000_0008, 32'd0, 4'h0, TO - 1, 32'h0102_0304);
      recv(8'h04, 0);
      recv(8'h03, 0);
      recv(8'h02, 0);
      recv(8'h01, 0);
      check_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
endmodule
